// File: rtl/multi_cell_pair_reader_pkg.sv
// Shared types and helpers for the multi-cell pair reader: FSM state encoding,
// default geometry and packed-slice arithmetic.
package multi_cell_pair_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REF_RD    = 3'd1,
        ST_REF_LATCH = 3'd2,
        ST_STREAM    = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    localparam int unsigned NUM_CELLS_DEF  = 14;
    localparam int unsigned PID_W_DEF      = 7;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned CELL_SEL_W_DEF = 4;
    localparam int unsigned COORDS         = 3;

    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/multi_cell_pair_reader_if.sv
// Bus bundle between the pair reader, the cell position memories and the filter pipeline.
interface multi_cell_pair_reader_if
    import multi_cell_pair_reader_pkg::*;
#(
    parameter int unsigned NUM_CELLS         = NUM_CELLS_DEF,
    parameter int unsigned PARTICLE_ID_WIDTH = PID_W_DEF,
    parameter int unsigned DATA_WIDTH        = DATA_W_DEF,
    parameter int unsigned CELL_SEL_WIDTH    = CELL_SEL_W_DEF
);
    logic                                      iter_start;
    logic [PARTICLE_ID_WIDTH-1:0]              home_particle_num;
    logic [NUM_CELLS*PARTICLE_ID_WIDTH-1:0]    nb_particle_num;
    logic                                      back_pressure;
    logic [PARTICLE_ID_WIDTH-1:0]              ref_rd_addr;
    logic [COORDS*DATA_WIDTH-1:0]              ref_rd_data;
    logic [PARTICLE_ID_WIDTH-1:0]              nb_rd_addr;
    logic [NUM_CELLS*COORDS*DATA_WIDTH-1:0]    nb_rd_data;
    logic                                      pair_valid;
    logic [PARTICLE_ID_WIDTH-1:0]              ref_id;
    logic [PARTICLE_ID_WIDTH-1:0]              nb_id;
    logic [CELL_SEL_WIDTH-1:0]                 nb_cell_id;
    logic [COORDS*DATA_WIDTH-1:0]              ref_pos;
    logic [COORDS*DATA_WIDTH-1:0]              nb_pos;
    logic                                      ref_last;
    logic [PARTICLE_ID_WIDTH-1:0]              ref_particle_num;
    logic                                      reading_done;

    modport master (
        input  iter_start, home_particle_num, nb_particle_num, back_pressure,
               ref_rd_data, nb_rd_data,
        output ref_rd_addr, nb_rd_addr, pair_valid, ref_id, nb_id, nb_cell_id,
               ref_pos, nb_pos, ref_last, ref_particle_num, reading_done
    );

    modport slave (
        output iter_start, home_particle_num, nb_particle_num, back_pressure,
               ref_rd_data, nb_rd_data,
        input  ref_rd_addr, nb_rd_addr, pair_valid, ref_id, nb_id, nb_cell_id,
               ref_pos, nb_pos, ref_last, ref_particle_num, reading_done
    );

endinterface

// File: rtl/multi_cell_pair_reader_nb_cell_mux.sv
// Neighbour position selector: the cell index of an issued read is registered so it
// lines up with the one-cycle memory latency, then picks that cell's word.
module multi_cell_pair_reader_nb_cell_mux
    import multi_cell_pair_reader_pkg::*;
#(
    parameter int unsigned NUM_CELLS = NUM_CELLS_DEF,
    parameter int unsigned WORD_W    = COORDS * DATA_W_DEF,
    parameter int unsigned SEL_W     = CELL_SEL_W_DEF
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_i,
    input  logic [SEL_W-1:0]              sel_i,
    input  logic [NUM_CELLS*WORD_W-1:0]   data_i,
    output logic [WORD_W-1:0]             data_o
);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic             vld_q, vld_d;

    // Capture the cell of the read being issued this cycle
    always_comb begin
        vld_d = load_i;
        if (load_i) begin
            sel_d = sel_i;
        end else begin
            sel_d = sel_q;
        end
    end

    // Select pipe register
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= {SEL_W{1'b0}};
            vld_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            vld_q <= vld_d;
        end
    end

    // Output is forced to zero whenever no pair is in flight
    always_comb begin
        data_o = {WORD_W{1'b0}};
        for (int unsigned c = 0; c < NUM_CELLS; c++) begin
            if (vld_q && (sel_q == SEL_W'(c))) begin
                data_o = data_i[slice_lsb(c, WORD_W) +: WORD_W];
            end else begin
                data_o = data_o;
            end
        end
    end

endmodule

// File: rtl/multi_cell_pair_reader.sv
// Walks each home-cell reference particle and streams (ref, neighbour) position pairs
// from the home cell (nb > ref only) and the half-shell neighbour cells.
module multi_cell_pair_reader
    import multi_cell_pair_reader_pkg::*;
#(
    parameter int unsigned NUM_CELLS         = NUM_CELLS_DEF,
    parameter int unsigned PARTICLE_ID_WIDTH = PID_W_DEF,
    parameter int unsigned DATA_WIDTH        = DATA_W_DEF,
    parameter int unsigned CELL_SEL_WIDTH    = CELL_SEL_W_DEF
)
(
    input  logic                      clk,
    input  logic                      rst,
    multi_cell_pair_reader_if.master  bus
);

    localparam int unsigned WORD_W = COORDS * DATA_WIDTH;
    typedef logic [PARTICLE_ID_WIDTH-1:0] pid_t;
    typedef logic [CELL_SEL_WIDTH-1:0]    cell_t;

    localparam pid_t  PID_ZERO  = pid_t'(0);
    localparam pid_t  PID_ONE   = pid_t'(1);
    localparam cell_t CELL_ZERO = cell_t'(0);
    localparam cell_t CELL_ONE  = cell_t'(1);
    localparam cell_t LAST_CELL = cell_t'(NUM_CELLS - 1);

    state_e             state_q, state_d;
    pid_t               ref_ptr_q, ref_ptr_d;
    pid_t               nb_ptr_q, nb_ptr_d;
    cell_t              cell_ptr_q, cell_ptr_d;
    pid_t               counts_q [NUM_CELLS];
    pid_t               counts_d [NUM_CELLS];
    logic [WORD_W-1:0]  ref_pos_q, ref_pos_d;
    logic               pair_valid_q, pair_valid_d;
    pid_t               ref_id_q, ref_id_d;
    pid_t               nb_id_q, nb_id_d;
    cell_t              nb_cell_id_q, nb_cell_id_d;
    logic               ref_last_q, ref_last_d;
    logic               done_q, done_d;

    logic               issue_s;
    logic               rest_empty_s;
    pid_t               cnt_sel_s;
    pid_t               nb_next_s;
    pid_t               ref_next_s;

    assign cnt_sel_s  = counts_q[cell_ptr_q];
    assign nb_next_s  = nb_ptr_q + PID_ONE;
    assign ref_next_s = ref_ptr_q + PID_ONE;

    // Lookahead so ref_last rides on the final issued pair rather than a trailing beat
    always_comb begin
        rest_empty_s = 1'b1;
        for (int unsigned c = 0; c < NUM_CELLS; c++) begin
            if ((cell_t'(c) > cell_ptr_q) && (counts_q[c] != PID_ZERO)) begin
                rest_empty_s = 1'b0;
            end else begin
                rest_empty_s = rest_empty_s;
            end
        end
    end

    // Next-state, pointer walk and issued-pair fields
    always_comb begin
        state_d      = state_q;
        ref_ptr_d    = ref_ptr_q;
        cell_ptr_d   = cell_ptr_q;
        nb_ptr_d     = nb_ptr_q;
        counts_d     = counts_q;
        ref_pos_d    = ref_pos_q;
        issue_s      = 1'b0;
        pair_valid_d = 1'b0;
        ref_id_d     = ref_id_q;
        nb_id_d      = nb_id_q;
        nb_cell_id_d = nb_cell_id_q;
        ref_last_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.iter_start) begin
                    for (int unsigned c = 0; c < NUM_CELLS; c++) begin
                        counts_d[c] = bus.nb_particle_num[slice_lsb(c, PARTICLE_ID_WIDTH) +: PARTICLE_ID_WIDTH];
                    end
                    counts_d[0] = bus.home_particle_num;
                    ref_ptr_d   = PID_ZERO;
                    cell_ptr_d  = CELL_ZERO;
                    nb_ptr_d    = PID_ZERO;
                    state_d     = (bus.home_particle_num == PID_ZERO) ? ST_DONE : ST_REF_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REF_RD: begin
                state_d = ST_REF_LATCH;
            end
            ST_REF_LATCH: begin
                ref_pos_d  = bus.ref_rd_data;
                cell_ptr_d = CELL_ZERO;
                nb_ptr_d   = ref_next_s;
                state_d    = ST_STREAM;
            end
            ST_STREAM: begin
                if (bus.back_pressure) begin
                    state_d = ST_STREAM;
                end else if (nb_ptr_q < cnt_sel_s) begin
                    issue_s      = 1'b1;
                    pair_valid_d = 1'b1;
                    ref_id_d     = ref_ptr_q;
                    nb_id_d      = nb_ptr_q;
                    nb_cell_id_d = cell_ptr_q;
                    ref_last_d   = (nb_next_s == cnt_sel_s) && rest_empty_s;
                    nb_ptr_d     = nb_next_s;
                end else if (cell_ptr_q != LAST_CELL) begin
                    cell_ptr_d = cell_ptr_q + CELL_ONE;
                    nb_ptr_d   = PID_ZERO;
                end else begin
                    ref_ptr_d = ref_next_s;
                    state_d   = (ref_next_s == counts_q[0]) ? ST_DONE : ST_REF_RD;
                end
            end
            ST_DONE: begin
                if (bus.iter_start) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // State, pointer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ref_ptr_q    <= PID_ZERO;
            cell_ptr_q   <= CELL_ZERO;
            nb_ptr_q     <= PID_ZERO;
            counts_q     <= '{default: PID_ZERO};
            ref_pos_q    <= {WORD_W{1'b0}};
            pair_valid_q <= 1'b0;
            ref_id_q     <= PID_ZERO;
            nb_id_q      <= PID_ZERO;
            nb_cell_id_q <= CELL_ZERO;
            ref_last_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ref_ptr_q    <= ref_ptr_d;
            cell_ptr_q   <= cell_ptr_d;
            nb_ptr_q     <= nb_ptr_d;
            counts_q     <= counts_d;
            ref_pos_q    <= ref_pos_d;
            pair_valid_q <= pair_valid_d;
            ref_id_q     <= ref_id_d;
            nb_id_q      <= nb_id_d;
            nb_cell_id_q <= nb_cell_id_d;
            ref_last_q   <= ref_last_d;
            done_q       <= done_d;
        end
    end

    multi_cell_pair_reader_nb_cell_mux #(
        .NUM_CELLS (NUM_CELLS),
        .WORD_W    (WORD_W),
        .SEL_W     (CELL_SEL_WIDTH)
    ) u_nb_cell_mux (
        .clk    (clk),
        .rst    (rst),
        .load_i (issue_s),
        .sel_i  (cell_ptr_q),
        .data_i (bus.nb_rd_data),
        .data_o (bus.nb_pos)
    );

    assign bus.ref_rd_addr      = ref_ptr_q;
    assign bus.nb_rd_addr       = nb_ptr_q;
    assign bus.pair_valid       = pair_valid_q;
    assign bus.ref_id           = ref_id_q;
    assign bus.nb_id            = nb_id_q;
    assign bus.nb_cell_id       = nb_cell_id_q;
    assign bus.ref_pos          = ref_pos_q;
    assign bus.ref_last         = ref_last_q;
    assign bus.ref_particle_num = counts_q[0];
    assign bus.reading_done     = done_q;

endmodule

// File: tb/tb_multi_cell_pair_reader.sv
// Bench for multi_cell_pair_reader: pair list built from the counts by plain loops,
// compared beat by beat against the DUT stream.
module tb_multi_cell_pair_reader;

    localparam int NC  = 14;
    localparam int PW  = 7;
    localparam int DW  = 32;
    localparam int CSW = 4;
    localparam int WW  = 3 * DW;

    typedef struct {
        int r;
        int n;
        int c;
        bit last;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_cell_pair_reader_if #(.NUM_CELLS(NC), .PARTICLE_ID_WIDTH(PW),
                                .DATA_WIDTH(DW), .CELL_SEL_WIDTH(CSW)) bus ();

    multi_cell_pair_reader #(.NUM_CELLS(NC), .PARTICLE_ID_WIDTH(PW),
                             .DATA_WIDTH(DW), .CELL_SEL_WIDTH(CSW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pairs_seen, last_seen, done_seen, first_pair_cyc, done_cyc, start_cyc, exp_total;
    bit          chk_en = 1'b0;
    bit          bp_rand = 1'b0;
    logic [31:0] salt = 32'd0;
    int          cnt [NC];
    pair_t       exp_q [$];
    pair_t       obs_q [$];
    pair_t       last_obs;
    int          c2_ref [6] = '{0, 0, 0, 1, 1, 2};
    int          c2_nb  [6] = '{1, 2, 3, 2, 3, 3};

    function automatic logic [WW-1:0] pos_of(input int c, input int idx);
        logic [31:0] x, y, z;
        x = salt ^ (32'(c) << 16) ^ 32'(idx);
        y = salt + 32'(c * 131 + idx * 7);
        z = ~salt ^ (32'(idx) << 8) ^ 32'(c);
        return {z, y, x};
    endfunction

    // position memories: one-cycle read latency
    always @(posedge clk) begin
        bus.ref_rd_data <= pos_of(0, int'(bus.ref_rd_addr));
        for (int c = 0; c < NC; c++) begin
            bus.nb_rd_data[c*WW +: WW] <= pos_of(c, int'(bus.nb_rd_addr));
        end
    end

    task automatic check_int(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_bool(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic pair_t obs_at(input int i);
        pair_t p;
        p = '{-1, -1, -1, 1'b0};
        if (i < obs_q.size()) p = obs_q[i];
        return p;
    endfunction

    task automatic check_outputs_zero(input string name);
        logic [233:0] v;
        v = {bus.ref_rd_addr, bus.nb_rd_addr, bus.pair_valid, bus.ref_id, bus.nb_id,
             bus.nb_cell_id, bus.ref_pos, bus.nb_pos, bus.ref_last, bus.ref_particle_num,
             bus.reading_done};
        check_bool(name, v == '0, $sformatf("outputs %h, expected all zero", v));
    endtask

    // one cycle: sample at negedge and compare every valid beat against the model
    task automatic tick();
        pair_t e;
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            if (bus.pair_valid) begin
                pairs_seen++;
                if (first_pair_cyc < 0) first_pair_cyc = cyc;
                if (bus.ref_last) last_seen++;
                last_obs = '{int'(bus.ref_id), int'(bus.nb_id), int'(bus.nb_cell_id), bus.ref_last};
                obs_q.push_back(last_obs);
                if (exp_q.size() == 0) begin
                    check_bool("unexpected_pair", 1'b0,
                        $sformatf("got ref=%0d nb=%0d cell=%0d, expected no pair",
                                  bus.ref_id, bus.nb_id, bus.nb_cell_id));
                end else begin
                    e = exp_q.pop_front();
                    check_bool("pair",
                        bus.ref_id == PW'(e.r) && bus.nb_id == PW'(e.n) &&
                        bus.nb_cell_id == CSW'(e.c) && bus.ref_last == e.last &&
                        bus.ref_pos == pos_of(0, e.r) && bus.nb_pos == pos_of(e.c, e.n),
                        $sformatf("got ref=%0d nb=%0d cell=%0d last=%0d rp=%h np=%h, expected ref=%0d nb=%0d cell=%0d last=%0d rp=%h np=%h",
                                  bus.ref_id, bus.nb_id, bus.nb_cell_id, bus.ref_last, bus.ref_pos, bus.nb_pos,
                                  e.r, e.n, e.c, e.last, pos_of(0, e.r), pos_of(e.c, e.n)));
                end
            end
            if (bus.reading_done) begin
                done_seen++;
                done_cyc = cyc;
                check_int("done_after_last_pair", exp_q.size(), 0);
            end
        end
        if (bp_rand) bus.back_pressure = ($urandom_range(0, 3) == 0);
    endtask

    task automatic build_model();
        int tot, k;
        exp_q.delete();
        for (int i = 0; i < cnt[0]; i++) begin
            tot = cnt[0] - 1 - i;
            for (int c = 1; c < NC; c++) tot += cnt[c];
            k = 0;
            for (int c = 0; c < NC; c++) begin
                for (int j = (c == 0) ? i + 1 : 0; j < cnt[c]; j++) begin
                    exp_q.push_back('{i, j, c, (k == tot - 1)});
                    k++;
                end
            end
        end
        exp_total = exp_q.size();
    endtask

    task automatic drive_counts();
        bus.home_particle_num = PW'(cnt[0]);
        bus.nb_particle_num[0 +: PW] = PW'(99);   // slot 0 must be ignored
        for (int c = 1; c < NC; c++) bus.nb_particle_num[c*PW +: PW] = PW'(cnt[c]);
    endtask

    task automatic run_iter(input int stall_at, input int rst_at);
        int budget, p0;
        bit stalled;
        stalled = 1'b0;
        salt = $urandom();
        build_model();
        drive_counts();
        obs_q.delete();
        pairs_seen = 0; last_seen = 0; done_seen = 0; first_pair_cyc = -1; done_cyc = -1;
        bus.iter_start = 1'b1;
        start_cyc = cyc;
        budget = 0;
        while (done_seen == 0 && budget < 40000) begin
            tick();
            budget++;
            if (budget == 2) begin
                bus.home_particle_num = PW'($urandom);
                for (int c = 0; c < NC; c++) bus.nb_particle_num[c*PW +: PW] = PW'($urandom);
            end
            if (stall_at >= 0 && !stalled && pairs_seen >= stall_at) begin
                stalled = 1'b1;
                bus.back_pressure = 1'b1;
                p0 = pairs_seen;
                repeat (5) tick();
                bus.back_pressure = 1'b0;
                check_bool("stall_pairs", pairs_seen - p0 <= 1,
                           $sformatf("got %0d pairs during stall, expected at most 1", pairs_seen - p0));
            end
            if (rst_at >= 0 && pairs_seen >= rst_at) begin
                rst = 1'b1;
                bus.iter_start = 1'b0;
                chk_en = 1'b0;
                tick();
                check_outputs_zero("rst_mid_stream");
                rst = 1'b0;
                chk_en = 1'b1;
                exp_q.delete();
                tick();
                return;
            end
        end
        check_bool("done_timeout", done_seen != 0, "reading_done not seen within cycle budget");
        repeat (3) tick();
        bus.iter_start = 1'b0;
        repeat (3) tick();
        check_int("done_pulses", done_seen, 1);
        check_int("model_drained", exp_q.size(), 0);
    endtask

    task automatic set_case1();
        cnt[0] = 3;
        for (int c = 1; c < NC; c++) cnt[c] = 2;
    endtask

    initial begin
        bus.iter_start = 1'b0;
        bus.back_pressure = 1'b0;
        bus.home_particle_num = '0;
        bus.nb_particle_num = '0;
        rst = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset_state");
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // home=3, neighbours 2 each
        set_case1();
        run_iter(-1, -1);
        check_int("c1_pairs", pairs_seen, 81);
        check_int("c1_ref_last", last_seen, 3);
        check_int("c1_first_pair_latency", first_pair_cyc - start_cyc, 4);
        check_int("c1_ref_particle_num", bus.ref_particle_num, 3);
        check_bool("c1_home_pairs",
                   obs_at(0).r == 0 && obs_at(0).n == 1 && obs_at(0).c == 0 &&
                   obs_at(1).r == 0 && obs_at(1).n == 2 && obs_at(1).c == 0 &&
                   obs_at(28).r == 1 && obs_at(28).n == 2 && obs_at(28).c == 0,
                   $sformatf("got (%0d,%0d) (%0d,%0d) (%0d,%0d), expected (0,1) (0,2) (1,2)",
                             obs_at(0).r, obs_at(0).n, obs_at(1).r, obs_at(1).n, obs_at(28).r, obs_at(28).n));

        // home=4, no neighbours
        cnt[0] = 4;
        for (int c = 1; c < NC; c++) cnt[c] = 0;
        run_iter(-1, -1);
        check_int("c2_pairs", pairs_seen, 6);
        check_int("c2_ref_last", last_seen, 3);
        for (int i = 0; i < 6; i++) begin
            check_bool("c2_order", obs_at(i).r == c2_ref[i] && obs_at(i).n == c2_nb[i] && obs_at(i).c == 0,
                       $sformatf("beat %0d got (%0d,%0d) cell %0d, expected (%0d,%0d) cell 0",
                                 i, obs_at(i).r, obs_at(i).n, obs_at(i).c, c2_ref[i], c2_nb[i]));
        end

        // empty home cell
        cnt[0] = 0;
        for (int c = 1; c < NC; c++) cnt[c] = 5;
        run_iter(-1, -1);
        check_int("c3_pairs", pairs_seen, 0);
        check_bool("c3_done_latency", done_cyc >= 0 && done_cyc - start_cyc <= 3,
                   $sformatf("got done %0d cycles after start, expected at most 3", done_cyc - start_cyc));

        // 5-cycle stall mid-stream
        set_case1();
        run_iter(20, -1);
        check_int("c4_pairs", pairs_seen, 81);
        check_int("c4_ref_last", last_seen, 3);

        // reset mid-stream then clean restart
        set_case1();
        run_iter(-1, 15);
        set_case1();
        run_iter(-1, -1);
        check_int("c5_pairs", pairs_seen, 81);
        check_int("c5_first_pair_latency", first_pair_cyc - start_cyc, 4);

        // randomized counts with random back-pressure
        bp_rand = 1'b1;
        for (int t = 0; t < 4; t++) begin
            cnt[0] = $urandom_range(0, 10);
            for (int c = 1; c < NC; c++) cnt[c] = $urandom_range(0, 3);
            run_iter(-1, -1);
            check_int("rand_pairs", pairs_seen, exp_total);
        end
        bp_rand = 1'b0;
        bus.back_pressure = 1'b0;
        tick();

        // full-size home cell plus one full neighbour
        for (int c = 0; c < NC; c++) cnt[c] = 0;
        cnt[0] = 127;
        cnt[5] = 127;
        run_iter(-1, -1);
        check_int("c6_pairs", pairs_seen, 24130);
        check_bool("c6_last_pair", last_obs.r == 126 && last_obs.c == 5 && last_obs.n == 126 && last_obs.last,
                   $sformatf("got ref=%0d cell=%0d nb=%0d last=%0d, expected ref=126 cell=5 nb=126 last=1",
                             last_obs.r, last_obs.c, last_obs.n, last_obs.last));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
